// File: rtl/fft_ctrl_pkg.sv
// Shared types and default sizing for the radix-2 FFT stage controller.
package fft_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, FILL, PAIR, DRAIN} state_t;

  localparam int HALF_BEATS_DEF = 16;
  localparam int BFLY_LAT_DEF   = 1;
  localparam int TWD_LAT_DEF    = 4;
endpackage

// File: rtl/valid_delay.sv
// Fixed-depth delay line for a valid-tagged word; bit 0 of the word is the valid.
module valid_delay #(
  parameter int DEPTH = 1,
  parameter int W     = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         any_vld_o
);
  logic [DEPTH-1:0][W-1:0] pipe_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_q <= '0;
    end else if (clr_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int k = 1; k < DEPTH; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign q_o = pipe_q[DEPTH-1];

  always_comb begin
    any_vld_o = 1'b0;
    for (int k = 0; k < DEPTH; k++) any_vld_o = any_vld_o | pipe_q[k][0];
  end
endmodule

// File: rtl/fft_stage_ctrl.sv
// Fill/pair/drain sequencer for one radix-2 FFT stage: delay-line enables,
// butterfly enables, twiddle index and latency-aligned output valid.
module fft_stage_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int HALF_BEATS = HALF_BEATS_DEF,
  parameter int BFLY_LAT   = BFLY_LAT_DEF,
  parameter int TWD_LAT    = TWD_LAT_DEF,
  parameter int IDX_W      = $clog2(2*HALF_BEATS)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             shift_en_o,
  output logic             bfly_en_o,
  output logic             drain_en_o,
  output logic             mul_en_o,
  output logic             out_sel_o,
  output logic [IDX_W-1:0] twd_idx_o,
  output logic             out_valid_o,
  output logic             frame_done_o,
  output logic             busy_o
);
  localparam int             CNT_W    = IDX_W - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_BEATS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(2*HALF_BEATS - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept, last_beat;

  assign in_ready_o = (state_q != DRAIN) && !flush_i;
  assign accept     = in_valid_i && in_ready_o;
  assign last_beat  = (cnt_q == CNT_LAST);
  assign shift_en_o = accept && ((state_q == IDLE) || (state_q == FILL));
  assign bfly_en_o  = accept && (state_q == PAIR);
  assign drain_en_o = (state_q == DRAIN);

  always_ff @(posedge clk_i or posedge rstn_i) begin
    if (rstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (flush_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        // The accepting beat is itself beat 0 of the fill.
        IDLE: if (accept) begin
          state_q <= FILL;
          cnt_q   <= CNT_W'(1);
        end
        FILL: if (accept) begin
          if (last_beat) begin
            state_q <= PAIR;
            cnt_q   <= '0;
          end else cnt_q <= cnt_q + 1'b1;
        end
        PAIR: if (accept) begin
          if (last_beat) begin
            state_q <= DRAIN;
            cnt_q   <= '0;
          end else cnt_q <= cnt_q + 1'b1;
        end
        DRAIN: begin
          if (last_beat) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else cnt_q <= cnt_q + 1'b1;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Pair beats carry idx 0..H-1, drain cycles H..2H-1; idle slots carry zero.
  logic                 ent_v;
  logic [IDX_W-1:0]     ent_idx;
  logic [IDX_W+1:0]     bfly_d, bfly_q;
  logic [1:0]           twd_d, twd_q;
  logic                 bfly_any, twd_any, last_mul;

  assign ent_v   = bfly_en_o || drain_en_o;
  assign ent_idx = ent_v ? {drain_en_o, cnt_q} : '0;
  assign bfly_d  = {ent_idx, drain_en_o, ent_v};

  valid_delay #(.DEPTH(BFLY_LAT), .W(IDX_W + 2)) u_bfly_dly (
    .clk_i     (clk_i),
    .rst_i     (rstn_i),
    .clr_i     (flush_i),
    .d_i       (bfly_d),
    .q_o       (bfly_q),
    .any_vld_o (bfly_any)
  );

  assign mul_en_o  = bfly_q[0];
  assign out_sel_o = bfly_q[1];
  assign twd_idx_o = bfly_q[IDX_W+1:2];
  assign last_mul  = mul_en_o && (twd_idx_o == IDX_LAST);
  assign twd_d     = {last_mul, mul_en_o};

  valid_delay #(.DEPTH(TWD_LAT), .W(2)) u_twd_dly (
    .clk_i     (clk_i),
    .rst_i     (rstn_i),
    .clr_i     (flush_i),
    .d_i       (twd_d),
    .q_o       (twd_q),
    .any_vld_o (twd_any)
  );

  assign out_valid_o  = twd_q[0];
  assign frame_done_o = twd_q[0] && twd_q[1];
  assign busy_o       = (state_q != IDLE) || bfly_any || twd_any;
endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Two controller configurations (H=16/TWD 4 and H=4/TWD 1) checked every cycle
// against a frame-level schedule model driven by directed and random beats.
module tb_fft_stage_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] in_valid = '0, flush = '0;
  logic [1:0] in_ready, shift_en, bfly_en, drain_en, mul_en, out_sel;
  logic [1:0] out_valid, frame_done, busy;
  logic [4:0] twd0;
  logic [2:0] twd1;

  fft_stage_ctrl #(.HALF_BEATS(16), .BFLY_LAT(1), .TWD_LAT(4)) u_dut0 (
    .clk_i(clk), .rstn_i(rst), .flush_i(flush[0]), .in_valid_i(in_valid[0]),
    .in_ready_o(in_ready[0]), .shift_en_o(shift_en[0]), .bfly_en_o(bfly_en[0]),
    .drain_en_o(drain_en[0]), .mul_en_o(mul_en[0]), .out_sel_o(out_sel[0]),
    .twd_idx_o(twd0), .out_valid_o(out_valid[0]), .frame_done_o(frame_done[0]),
    .busy_o(busy[0]));

  fft_stage_ctrl #(.HALF_BEATS(4), .BFLY_LAT(1), .TWD_LAT(1)) u_dut1 (
    .clk_i(clk), .rstn_i(rst), .flush_i(flush[1]), .in_valid_i(in_valid[1]),
    .in_ready_o(in_ready[1]), .shift_en_o(shift_en[1]), .bfly_en_o(bfly_en[1]),
    .drain_en_o(drain_en[1]), .mul_en_o(mul_en[1]), .out_sel_o(out_sel[1]),
    .twd_idx_o(twd1), .out_valid_o(out_valid[1]), .frame_done_o(frame_done[1]),
    .busy_o(busy[1]));

  int checks = 0, failures = 0;
  int HB[2] = '{16, 4};
  int BL[2] = '{1, 1};
  int TL[2] = '{4, 1};

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Stimulus queues: one {flush, valid} entry per cycle per instance.
  logic [1:0] q0[$], q1[$];

  task automatic add(input int i, input bit v, input bit f, input int n);
    for (int k = 0; k < n; k++) begin
      if (i == 0) q0.push_back({f, v});
      else        q1.push_back({f, v});
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) {flush[0], in_valid[0]} = q0.pop_front();
      else               {flush[0], in_valid[0]} = 2'b00;
      if (q1.size() > 0) {flush[1], in_valid[1]} = q1.pop_front();
      else               {flush[1], in_valid[1]} = 2'b00;
    end
  end

  // Reference: nacc = beats accepted in the current frame (2H means draining),
  // dleft = drain cycles remaining; outputs are scheduled into time-indexed rings.
  int nacc[2], dleft[2], tcur = 0, fd_cnt[2];
  bit sm_v[2][64], so_v[2][64];
  int sm_idx[2][64], so_idx[2][64];
  int h, r, ob;
  bit drn, acc, eb, emul, eov;

  task automatic model_clear(input int i);
    nacc[i] = 0;
    dleft[i] = 0;
    for (int k = 0; k < 64; k++) begin
      sm_v[i][k] = 0; so_v[i][k] = 0; sm_idx[i][k] = 0; so_idx[i][k] = 0;
    end
  endtask

  task automatic sched(input int i, input int idx);
    int m, o;
    m = (tcur + BL[i]) % 64;
    o = (tcur + BL[i] + TL[i]) % 64;
    sm_v[i][m] = 1; sm_idx[i][m] = idx;
    so_v[i][o] = 1; so_idx[i][o] = idx;
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) model_clear(i);
      h   = HB[i];
      r   = tcur % 64;
      drn = (nacc[i] == 2*h);
      acc = in_valid[i] && !drn && !flush[i];
      emul = sm_v[i][r];
      eov  = so_v[i][r];
      eb   = (nacc[i] > 0);
      for (int k = 0; k < BL[i]; k++) if (sm_v[i][(tcur+k)%64]) eb = 1;
      for (int k = 0; k < TL[i]; k++) if (so_v[i][(tcur+k)%64]) eb = 1;
      ob = (i == 0) ? int'(twd0) : int'(twd1);
      chk($sformatf("i%0d.in_ready", i),   int'(in_ready[i]),   int'(!drn && !flush[i]));
      chk($sformatf("i%0d.shift_en", i),   int'(shift_en[i]),   int'(acc && nacc[i] < h));
      chk($sformatf("i%0d.bfly_en", i),    int'(bfly_en[i]),    int'(acc && nacc[i] >= h));
      chk($sformatf("i%0d.drain_en", i),   int'(drain_en[i]),   int'(drn));
      chk($sformatf("i%0d.mul_en", i),     int'(mul_en[i]),     int'(emul));
      chk($sformatf("i%0d.out_sel", i),    int'(out_sel[i]),    int'(emul && sm_idx[i][r] >= h));
      chk($sformatf("i%0d.twd_idx", i),    ob,                  emul ? sm_idx[i][r] : 0);
      chk($sformatf("i%0d.out_valid", i),  int'(out_valid[i]),  int'(eov));
      chk($sformatf("i%0d.frame_done", i), int'(frame_done[i]), int'(eov && so_idx[i][r] == 2*h-1));
      chk($sformatf("i%0d.busy", i),       int'(busy[i]),       int'(eb));
      if (frame_done[i]) fd_cnt[i]++;
      sm_v[i][r] = 0;
      so_v[i][r] = 0;
      if (!rst) begin
        if (flush[i]) model_clear(i);
        else if (acc) begin
          if (nacc[i] >= h) sched(i, nacc[i] - h);
          nacc[i]++;
          if (nacc[i] == 2*h) dleft[i] = h;
        end else if (drn) begin
          sched(i, 2*h - dleft[i]);
          dleft[i]--;
          if (dleft[i] == 0) nacc[i] = 0;
        end
      end
    end
    tcur++;
  end

  task automatic start();
    fd_cnt[0] = 0;
    fd_cnt[1] = 0;
  endtask

  task automatic run(input string nm, input int exp_fd);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    chk({nm, ".done_in_time"}, int'(n < 5000), 1);
    if (exp_fd >= 0) begin
      chk({nm, ".i0.frames"}, fd_cnt[0], exp_fd);
      chk({nm, ".i1.frames"}, fd_cnt[1], exp_fd);
    end
    #2;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    start();
    for (int i = 0; i < 2; i++) begin
      add(i, 1, 0, 2*HB[i]);
      add(i, 0, 0, HB[i] + 12);
    end
    run("single", 1);

    start();
    for (int i = 0; i < 2; i++) begin
      add(i, 1, 0, HB[i]/2); add(i, 0, 0, 3); add(i, 1, 0, HB[i] - HB[i]/2);
      add(i, 1, 0, HB[i]/4); add(i, 0, 0, 2); add(i, 1, 0, HB[i] - HB[i]/4);
      add(i, 0, 0, HB[i] + 12);
    end
    run("stall", 1);

    start();
    for (int i = 0; i < 2; i++) begin
      add(i, 1, 0, 6*HB[i]);
      add(i, 0, 0, HB[i] + 12);
    end
    run("b2b", 2);

    start();
    for (int i = 0; i < 2; i++) begin
      add(i, 1, 0, HB[i] + ((HB[i] > 10) ? 10 : HB[i] - 1));
      add(i, 1, 1, 1);
      add(i, 0, 0, 10);
    end
    run("flush", 0);

    start();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 600; k++) add(i, ($urandom % 4) != 0, ($urandom % 50) == 0, 1);
      add(i, 0, 1, 1);
      add(i, 0, 0, 20);
    end
    run("random", -1);

    // Reset lands in DRAIN for both instances.
    add(0, 1, 0, 32); add(0, 0, 0, 30);
    add(1, 0, 0, 30); add(1, 1, 0, 8); add(1, 0, 0, 30);
    repeat (40) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst.i0.in_ready", int'(in_ready[0]), 1);
    chk("rst.i1.in_ready", int'(in_ready[1]), 1);
    chk("rst.i0.drain_en", int'(drain_en[0]), 0);
    chk("rst.i1.drain_en", int'(drain_en[1]), 0);
    chk("rst.i0.mul_en", int'(mul_en[0]), 0);
    chk("rst.i0.out_valid", int'(out_valid[0]), 0);
    chk("rst.i0.twd_idx", int'(twd0), 0);
    chk("rst.i0.busy", int'(busy[0]), 0);
    chk("rst.i1.busy", int'(busy[1]), 0);
    @(posedge clk);
    #3 rst = 1'b0;
    q0.delete();
    q1.delete();
    start();
    for (int i = 0; i < 2; i++) begin
      add(i, 1, 0, 2*HB[i]);
      add(i, 0, 0, HB[i] + 12);
    end
    run("post_reset", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fft_stage_ctrl.md
# fft_stage_ctrl

Sequencing controller for one radix-2 FFT stage (16 samples/beat, 32 beats/frame) that drives the stage's delay shift register, butterfly and twiddle multiplier. It accepts one input beat per cycle under a valid/ready handshake and tracks fill, pair and drain phases. It generates the shift, butterfly and output-mux enables, the twiddle index, and the aligned output valid, replacing the free-running pulse counters around each stage.

## Interface
- HALF_BEATS, 16: beats per half frame; delay depth in beats; power of two, ≥2
- BFLY_LAT, 1: butterfly register latency in cycles, ≥1
- TWD_LAT, 4: twiddle multiplier latency in cycles, ≥1
- IDX_W, $clog2(2*HALF_BEATS): derived twiddle index width

- clk  in  1  stage clock; single clock domain
- rstn  in  1  asynchronous, active-high reset; asserted = 1 despite the name
- flush  in  1  synchronous abort of the current frame
- in_valid  in  1  input beat offered
- in_ready  out  1  beat accepted when in_valid && in_ready
- shift_en  out  1  write the accepted beat into the delay shift register (FILL)
- bfly_en  out  1  accepted beat pairs with the delay output in the butterfly (PAIR)
- drain_en  out  1  shift the delay register with no new input (DRAIN)
- mul_en  out  1  twiddle multiplier input valid
- out_sel  out  1  multiplier source: 0 = butterfly sum, 1 = delayed diff
- twd_idx  out  IDX_W  twiddle ROM index, aligned with mul_en
- out_valid  out  1  stage output valid, mul_en delayed TWD_LAT
- frame_done  out  1  one-cycle pulse on the last out_valid of a frame
- busy  out  1  state ≠ IDLE, or any pipeline valid still set

## Operation
- States: IDLE, FILL, PAIR, DRAIN. beat_cnt runs 0..HALF_BEATS-1 and advances only on an accepted beat (FILL/PAIR) or on every cycle (DRAIN).
- IDLE: in_ready = 1. An accepted beat → FILL with beat_cnt = 1. The beat itself is a FILL beat, so shift_en = 1.
- FILL: shift_en = in_valid && in_ready. After beat HALF_BEATS-1 is accepted → PAIR, beat_cnt = 0.
- PAIR: bfly_en = accepted. The diff is pushed into the delay. After beat HALF_BEATS-1 → DRAIN.
- DRAIN: in_ready = 0 and drain_en = 1 for exactly HALF_BEATS cycles, then → IDLE. A gap in in_valid stalls FILL/PAIR; all counters hold and the enables are 0.
- in_ready = (state ≠ DRAIN) && !flush.
- shift_en, bfly_en and drain_en are combinational from the registered state and in_valid.
- mul_en/out_sel/twd_idx pipeline: PAIR beats enter with sel = 0 and idx = beat_cnt. DRAIN cycles enter with sel = 1 and idx = HALF_BEATS + beat_cnt. Both are delayed BFLY_LAT cycles before appearing on mul_en/out_sel/twd_idx.
- out_valid = mul_en delayed TWD_LAT cycles. frame_done = out_valid && the delayed idx == 2*HALF_BEATS-1.
- flush: next state is IDLE, beat_cnt = 0, and all pipeline valids clear on the next edge. flush wins over a simultaneous in_valid, and that beat is not accepted.
- Reset (async): state IDLE, counters 0, all pipeline stages 0.
- Reset values: in_ready = 1 (IDLE), every other output 0, twd_idx = 0.

## Timing
- A beat accepted at cycle t produces shift_en/bfly_en in cycle t, with no added latency.
- The first PAIR beat at cycle p gives mul_en at p+BFLY_LAT and out_valid at p+BFLY_LAT+TWD_LAT.
- With no stalls, a frame occupies 3*HALF_BEATS controller cycles: 16 FILL, 16 PAIR, 16 DRAIN.
- 2*HALF_BEATS out_valid beats are contiguous, and twd_idx runs 0..31 in order.
- The next frame's first beat can be accepted the cycle after the last DRAIN cycle.
- A stall during PAIR inserts matching gaps in mul_en/out_valid; twd_idx does not advance during a gap.
- A beat offered during DRAIN sees in_ready = 0 and must be held by the source.
- The output pipeline keeps draining after the state returns to IDLE. busy stays 1 until out_valid of the last beat.

## Structure
- Package fft_ctrl_pkg holds:
  - the typedef enum logic [1:0] state_t {IDLE, FILL, PAIR, DRAIN};
  - defaults for HALF_BEATS, BFLY_LAT and TWD_LAT.
- Sub-module valid_delay (parameters DEPTH, W) is instantiated twice: BFLY_LAT for {valid, sel, idx} and TWD_LAT for {valid, last}. Both instances clear on reset and on flush.
- The FSM and beat counter sit in fft_stage_ctrl itself.

## Test plan
- Single frame: 32 contiguous beats. Check 16 shift_en, 16 bfly_en, 16 drain_en; out_valid for 32 cycles starting 5 cycles after the first PAIR beat; twd_idx 0..31; frame_done at idx 31.
- Stall: drop in_valid for 3 cycles at FILL beat 8 and 2 cycles at PAIR beat 4. Counters hold; out_valid has a 2-cycle gap; the idx sequence stays 0..31 with no repeats.
- Back-to-back: hold in_valid high for 2 frames. in_ready is low for exactly 16 cycles per DRAIN; the second frame's outputs follow with idx restarting at 0.
- flush at PAIR beat 10 together with in_valid = 1: the beat is not accepted; next state is IDLE; mul_en/out_valid are 0 from the following cycle; no frame_done.
- Async reset mid-DRAIN: outputs go to reset values immediately; in_ready = 1 after release; a new frame runs cleanly.
- Parameter sweep: HALF_BEATS = 4, TWD_LAT = 1. Latency is BFLY_LAT+TWD_LAT = 2; idx runs 0..7.
